// File: rtl/det_sched_pkg.sv
// Shared types and helpers for det_stream_sched: FSM state encoding,
// counter width derivation and frame-length clamping.
package det_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        RESP
    } state_t;

    // Width that can hold every value 0..frame_w inclusive.
    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 1);
    endfunction

    function automatic int clamp_len(input int len, input int frame_w);
        return (len > frame_w) ? frame_w : len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping.
// Purely combinational; grant is one-hot and all-zero when disabled.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] cand;
    logic           found;
    int             pos;
    int             win_int;

    always_comb begin
        dbl     = {req, req} >> ptr;
        cand    = '0;
        found   = 1'b0;
        pos     = 0;
        for (int j = 0; j < N; j++) begin
            cand = dbl >> j;
            if (!found && cand[0]) begin
                found = 1'b1;
                pos   = j;
            end
        end
        win_int = (int'(ptr) + pos) % N;
        win     = IW'(win_int);
        gnt     = (en && found) ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
    end

endmodule

// File: rtl/det_stream_sched.sv
// Shares one serial sequence detector among NREQ requesters: grants frames
// round-robin, clears the detector, shifts the frame LSB-first and returns
// a hit result. Build option HIT_COUNT_EN adds the rsp_count hit counter.
module det_stream_sched
    import det_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int FRAME_W = 16,
    localparam int CNT_W   = cnt_width(FRAME_W),
    localparam int ID_W    = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*FRAME_W-1:0] req_data,
    input  logic [NREQ*CNT_W-1:0]   req_len,
    output logic                    det_rst_n,
    output logic                    det_in,
    input  logic                    det_dec,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_hit
`ifdef HIT_COUNT_EN
    ,
    output logic [CNT_W-1:0]        rsp_count
`endif
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               prev_shift_q, prev_shift_d;
    logic               hit_q, hit_d;
    logic               det_rst_n_q, det_rst_n_d;
    logic               det_in_q, det_in_d;
    logic               rsp_valid_q, rsp_valid_d;
`ifdef HIT_COUNT_EN
    logic [CNT_W-1:0]   count_q, count_d;
`endif

    logic [NREQ-1:0]    gnt;
    logic [ID_W-1:0]    win;
    logic               arb_en;
    logic               accept;
    logic [FRAME_W-1:0] sel_data;
    logic [CNT_W-1:0]   sel_len;
    logic [CNT_W-1:0]   clamped_len;
    logic [FRAME_W-1:0] shifted;

    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .N  (NREQ),
        .IW (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (gnt),
        .win (win)
    );

    assign req_ready   = gnt;
    assign accept      = |gnt;
    assign sel_data    = FRAME_W'(req_data >> (win * FRAME_W));
    assign sel_len     = CNT_W'(req_len >> (win * CNT_W));
    assign clamped_len = CNT_W'(clamp_len(int'(sel_len), FRAME_W));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        data_d   = data_q;
        len_d    = len_q;
        idx_d    = idx_q;
        hit_d    = hit_q;
`ifdef HIT_COUNT_EN
        count_d  = count_q;
`endif

        // det_dec lags det_in by one cycle, so sample only right after SHIFT.
        if (prev_shift_q && det_dec) begin
            hit_d   = 1'b1;
`ifdef HIT_COUNT_EN
            count_d = count_q + 1'b1;
`endif
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = win;
                    data_d  = sel_data;
                    len_d   = clamped_len;
                    ptr_d   = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
                    hit_d   = 1'b0;
`ifdef HIT_COUNT_EN
                    count_d = '0;
`endif
                    state_d = (clamped_len != '0) ? CLEAR : RESP;
                end
            end
            CLEAR: begin
                idx_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (idx_q == len_q - 1'b1) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        prev_shift_d = (state_q == SHIFT);
        det_rst_n_d  = (state_d == SHIFT) || (state_d == DRAIN);
        shifted      = data_d >> idx_d;
        det_in_d     = (state_d == SHIFT) && shifted[0];
        rsp_valid_d  = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            idx_q        <= '0;
            prev_shift_q <= 1'b0;
            hit_q        <= 1'b0;
            det_rst_n_q  <= 1'b0;
            det_in_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
`ifdef HIT_COUNT_EN
            count_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            idx_q        <= idx_d;
            prev_shift_q <= prev_shift_d;
            hit_q        <= hit_d;
            det_rst_n_q  <= det_rst_n_d;
            det_in_q     <= det_in_d;
            rsp_valid_q  <= rsp_valid_d;
`ifdef HIT_COUNT_EN
            count_q      <= count_d;
`endif
        end
        data_q <= data_d;
        len_q  <= len_d;
    end

    assign det_rst_n = det_rst_n_q;
    assign det_in    = det_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_hit   = hit_q;
`ifdef HIT_COUNT_EN
    assign rsp_count = count_q;
`endif

endmodule
